// File: rtl/data_mem_responder.sv
// Multi-cycle word memory responder for the pipelined datapath's load/store
// port. Requests are captured in IDLE, held for LATENCY wait states, then the
// word access is performed with a one-cycle Ready pulse. Stall freezes the
// pipeline while a request is outstanding.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Stall,
  output logic              Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rd_q;
  logic               wr_q;
  logic               mis_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               access;
  logic               write_en;

  // Upper address bits only alias onto the array; they carry no function.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Address[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  // Access happens on the edge that leaves BUSY with an expired counter.
  assign access   = (state == BUSY) && (cnt == '0);
  assign write_en = access && wr_q && !mis_q;

  // Freeze request; reset forces it low even when a request is presented.
  assign Stall = Rst && (MemRead || MemWrite) && !Ready;

  // Request capture, wait-state countdown, and registered response.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ReadData <= '0;
      Ready    <= 1'b0;
      Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            mis_q   <= (Address[1:0] != 2'b00);
            idx_q   <= Address[IDX_W+1:2];
            wdata_q <= WriteData;
            cnt     <= CNT_W'(LATENCY);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            Ready <= 1'b1;
            if (mis_q) begin
              Err      <= 1'b1;
              ReadData <= '0;
            end else begin
              Err <= 1'b0;
              // Read-before-write: the array update lands on this same edge.
              if (rd_q) ReadData <= mem[idx_q];
            end
            state <= DONE;
          end
        end
        DONE: begin
          Ready <= 1'b0;
          Err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word array; intentionally not cleared by reset.
  always_ff @(posedge Clk) begin
    if (write_en) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array reference model
// predicts each response, a monitor compares on every Ready pulse.
module tb_data_mem_responder;

  localparam int L0 = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  logic        MemRead0, MemWrite0, Ready0, Stall0, Err0;
  logic [31:0] Address0, WriteData0, ReadData0;
  logic        MemRead1, MemWrite1, Ready1, Stall1, Err1;
  logic [31:0] Address1, WriteData1, ReadData1;

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(L0)) dut (
    .Clk(Clk), .Rst(Rst), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .Address(Address0), .WriteData(WriteData0), .ReadData(ReadData0),
    .Ready(Ready0), .Stall(Stall0), .Err(Err0)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) dut_l0 (
    .Clk(Clk), .Rst(Rst), .MemRead(MemRead1), .MemWrite(MemWrite1),
    .Address(Address1), .WriteData(WriteData1), .ReadData(ReadData1),
    .Ready(Ready1), .Stall(Stall1), .Err(Err1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_n;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem_m [256];
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Ready pulse of the LATENCY=2 instance consumes one expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst && Ready0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got Ready=1, expected no pending request");
      end else begin
        e = sbq.pop_front();
        chk("rdata", ReadData0, e.data);
        chk("err", {31'b0, Err0}, {31'b0, e.err});
        chk("ready_cycle", 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  // Issue one request (called at a negedge with the DUT idle), predict it,
  // hold it until Ready, optionally scrambling Address/WriteData while busy.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit scramble);
    exp_t       e;
    logic [7:0] idx;
    int         n;
    bit         got;
    idx = a[9:2];
    if (a[1:0] != 2'b00) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      e.err  = 1'b0;
      e.data = rd ? mem_m[idx] : last_rd;
      if (wr) mem_m[idx] = wd;
    end
    last_rd  = e.data;
    e.edge_n = cyc + 2 + L0;
    sbq.push_back(e);

    MemRead0 = rd; MemWrite0 = wr; Address0 = a; WriteData0 = wd;
    #1 chk("stall_on_request", {31'b0, Stall0}, 32'd1);
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (Ready0) begin
        got = 1;
        chk("stall_at_ready", {31'b0, Stall0}, 32'd0);
      end else begin
        if (Stall0) n++;
        if (scramble) begin
          Address0   = $urandom;
          WriteData0 = $urandom;
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no Ready in 20 cycles, expected Ready");
    end
    chk("stall_cycles", 32'(n), 32'(L0 + 1));
    MemRead0 = 0; MemWrite0 = 0;
    @(negedge Clk);
  endtask

  initial begin
    logic [31:0] a;
    logic        rd, wr;
    int          c;
    bit          got;

    Rst = 1'b0;
    MemRead0 = 1'b1; MemWrite0 = 0; Address0 = '0; WriteData0 = '0;
    MemRead1 = 0; MemWrite1 = 0; Address1 = '0; WriteData1 = '0;
    #12;
    chk("reset_ready", {31'b0, Ready0}, 32'd0);
    chk("reset_err", {31'b0, Err0}, 32'd0);
    chk("reset_rdata", ReadData0, 32'd0);
    chk("reset_stall", {31'b0, Stall0}, 32'd0);
    MemRead0 = 0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Give every word a known value.
    for (int i = 0; i < 256; i++) do_op(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // Directed cases.
    do_op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_op(1'b0, 1'b1, 32'h004, 32'h11, 1'b0);
    do_op(1'b1, 1'b0, 32'h404, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 32'h006, 32'h0, 1'b0);
    do_op(1'b0, 1'b1, 32'h006, 32'hBAD0BAD0, 1'b0);
    do_op(1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    do_op(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_op(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b1);
    do_op(1'b1, 1'b0, 32'h80, 32'h0, 1'b1);

    // Random traffic with aliasing, misalignment and busy-time input churn.
    for (int i = 0; i < 200; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      do_op(rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
    end

    // Make ReadData nonzero, then abort a store to 0x10 mid-BUSY.
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    MemWrite0 = 1'b1; Address0 = 32'h10; WriteData0 = ~mem_m[4];
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("abort_ready", {31'b0, Ready0}, 32'd0);
    chk("abort_err", {31'b0, Err0}, 32'd0);
    chk("abort_rdata", ReadData0, 32'd0);
    chk("abort_stall", {31'b0, Stall0}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    MemWrite0 = 1'b0;
    last_rd = '0;
    @(negedge Clk);
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // LATENCY=0 instance: store then load with one-edge wait.
    MemWrite1 = 1'b1; Address1 = 32'h40; WriteData1 = 32'h55;
    c = cyc;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clk);
      if (Ready1) got = 1;
    end
    chk("l0_store_ready_cycle", 32'(cyc), 32'(c + 2));
    MemWrite1 = 1'b0;
    @(negedge Clk);

    // Hold MemRead continuously: Ready every third cycle, DONE ignores it.
    MemRead1 = 1'b1;
    c = cyc;
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      chk("l0_ready_pattern", {31'b0, Ready1}, {31'b0, (k == 2 || k == 5 || k == 8)});
      if (Ready1) begin
        chk("l0_rdata", ReadData1, 32'h55);
        chk("l0_err", {31'b0, Err1}, 32'd0);
      end
    end
    MemRead1 = 1'b0;
    @(negedge Clk);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
